muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, holds the operation for a fixed latency while asserting busy, then commits to HI/LO.
- Drives the stall request that freezes IF/ID when an HI/LO-class instruction in ID must wait on an in-flight operation.
- Sits beside the ALU in EX. MFHI/MFLO read the hi/lo outputs.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (range 1..31).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (range 1..31).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is an HI/LO-writing op this cycle.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MT source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- cancel  input  1  exception or interrupt flush of EX this cycle; suppresses start.
- id_md  input  1  ID-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  output  1  operation in flight.
- stall_req  output  1  to hazard unit; freeze PC and IF/ID, bubble ID/EX.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (clk edge with reset=1): hi=0, lo=0, busy=0, counter=0, state IDLE, pending results cleared. Reset overrides every other input, including mid-operation; the pending result is discarded and never committed.
- accept = start & ~cancel & (state==IDLE). start while RUN is ignored (hazard unit guarantees this cannot occur; bench flags it).
- States:
  - IDLE: busy=0. accept with md_op 0..3 sets pend_hi/pend_lo from combinational result, counter = MULT_CYCLES or DIV_CYCLES, and moves to RUN. accept with md_op 4 sets hi=rs_val on that edge; md_op 5 sets lo=rs_val; state stays IDLE. md_op 6/7: nothing.
  - RUN: busy=1; counter decrements each edge. On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, busy->0, state->IDLE.
- Latency: busy is high for exactly N cycles after the accept edge. New hi/lo are visible the first cycle busy is low.
- MULT: signed 32x32->64; MULTU unsigned. hi=upper 32 bits, lo=lower 32 bits.
- DIV: signed, quotient truncates toward zero, remainder takes dividend sign. lo=quotient, hi=remainder. DIVU unsigned.
- Divide by zero (rt_val==0): full DIV_CYCLES busy; hi/lo keep their prior values at commit.
- 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_req = id_md & (busy | (start & ~cancel & md_op<=3)), combinational. An MFHI in ID while a MULT is in EX therefore stalls.
- stall_req is never asserted when id_md=0. Independent instructions proceed during busy.
- cancel in RUN does not abort the in-flight operation; the instruction has already passed EX.
- hi/lo change only on commit, MT writes, or reset.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=-7 (0xFFFFFFF9) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1.
- MTHI rs=0x12345678 with no op in flight -> hi=0x12345678 on the next edge, busy stays 0. DIVU by 0 -> hi=0x12345678 unchanged after 10 cycles.
- MULT accepted with id_md=1 (MFLO in ID) -> stall_req=1 in the accept cycle and all 5 busy cycles, 0 after. id_md=0 during busy -> stall_req=0.
- start=1 with cancel=1 -> no state change, busy stays 0, stall_req follows id_md & busy only.
- reset asserted in the 3rd busy cycle of MULT -> next cycle busy=0, hi=lo=0, no later commit. 0x80000000 DIV -1 -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide controller owning the HI/LO pair.
// Results are computed combinationally at accept time. They are held as
// pending values while busy counts down, then committed to HI/LO.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation in flight; MTHI/MTLO write directly
// S_RUN  | MULT/DIV in flight; counter runs down, commit at count 1
module muldiv_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        cancel,
   input  logic        id_md,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic               accept;
   logic               div_zero;
   logic               div_ovf;
   logic [31:0]        rt_safe;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] quot_s, rem_s;
   logic [31:0]        quot_u, rem_u;
   logic [31:0]        res_hi, res_lo;

   assign accept = start & ~cancel & (state_q == S_IDLE);

   // Arithmetic results for the operation presented this cycle.
   always_comb begin
      div_zero = (rt_val == 32'd0);
      // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
      rt_safe  = div_zero ? 32'd1 : rt_val;
      // The most-negative / -1 quotient overflows 32 bits; it wraps to itself.
      div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
      prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
      prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
      quot_s   = div_ovf ? 32'sh8000_0000 : ($signed(rs_val) / $signed(rt_safe));
      rem_s    = div_ovf ? 32'sd0 : ($signed(rs_val) % $signed(rt_safe));
      quot_u   = rs_val / rt_safe;
      rem_u    = rs_val % rt_safe;
      res_hi   = 32'd0;
      res_lo   = 32'd0;
      case (md_op)
         3'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         3'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         3'd2: begin res_hi = rem_s;         res_lo = quot_s;        end
         3'd3: begin res_hi = rem_u;         res_lo = quot_u;        end
         default: ;
      endcase
   end

   // Next-state logic: accept, countdown and commit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (md_op)
                  3'd0, 3'd1: begin
                     pend_hi_d = res_hi;
                     pend_lo_d = res_lo;
                     pend_wr_d = 1'b1;
                     cnt_d     = MULT_N;
                     state_d   = S_RUN;
                  end
                  3'd2, 3'd3: begin
                     pend_hi_d = res_hi;
                     pend_lo_d = res_lo;
                     pend_wr_d = ~div_zero;
                     cnt_d     = DIV_N;
                     state_d   = S_RUN;
                  end
                  3'd4: hi_d = rs_val;
                  3'd5: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_IDLE;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and architectural registers; reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign stall_req = id_md & (busy | (start & ~cancel & (md_op <= 3'd3)));
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule
